// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with redirect handling and a one-entry skid buffer.
// Latency: one cycle from memory accept to instruction/pc/out_valid; one instruction per cycle.
// Backpressure: stall_pipeline holds outputs and parks one fetched word; imem_ready=0 keeps the request stable.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   stall_pipeline        ID is not advancing; IF outputs hold
//   is_jump, jump_addr    unconditional jump from ID (word address)
//   branch_taken, branch_addr  taken branch from MEM (word address), higher priority than jump
//   imem_req, imem_addr   instruction memory request and word address
//   imem_ready, imem_rdata  memory accept strobe and read data
//   instruction, pc       registered instruction and its word address to ID
//   out_valid             instruction/pc carry a real fetched instruction
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pipeline,
  input  logic        is_jump,
  input  logic [31:0] jump_addr,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] fetch_pc_inc;

  // Branch from MEM is older than the jump in ID, so it wins outright.
  assign redirect        = branch_taken | is_jump;
  assign redirect_target = branch_taken ? branch_addr : jump_addr;

  // Wraps modulo 2^32 with no overflow indication.
  assign fetch_pc_inc = fetch_pc_q + 32'd1;

  // fetch_pc is not advanced until a drain completes, so it still names the
  // outstanding request while in S_DRAIN.
  assign imem_addr = fetch_pc_q;
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign out_valid   = valid_q;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    redirect_pc_d = redirect_pc_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    valid_d       = valid_q;

    // A redirect squashes whatever ID is holding, even under stall.
    if (redirect) begin
      instr_d = NOP_INSTR;
      pc_d    = 32'd0;
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_RESET: begin
        // No request has been issued yet; the first fetch is always RESET_PC.
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect) begin
          if (imem_ready) begin
            // Returning word belongs to the wrong path: drop it.
            fetch_pc_d = redirect_target;
          end else begin
            // Request must stay stable until accepted; remember where to go.
            redirect_pc_d = redirect_target;
            state_d       = S_DRAIN;
          end
        end else if (imem_ready) begin
          fetch_pc_d = fetch_pc_inc;
          if (stall_pipeline) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = fetch_pc_q;
            state_d      = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc_d    = fetch_pc_q;
            valid_d = 1'b1;
          end
        end else if (!stall_pipeline) begin
          // ID consumed its instruction but nothing arrived: bubble.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // Parked word is on the wrong path; abandon it.
          fetch_pc_d = redirect_target;
          state_d    = S_FETCH;
        end else if (!stall_pipeline) begin
          instr_d = hold_instr_q;
          pc_d    = hold_pc_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        instr_d = NOP_INSTR;
        pc_d    = 32'd0;
        valid_d = 1'b0;
        if (redirect) begin
          redirect_pc_d = redirect_target;
        end
        if (imem_ready) begin
          // A redirect arriving on the completing cycle takes effect directly.
          fetch_pc_d = redirect ? redirect_target : redirect_pc_q;
          state_d    = S_FETCH;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RESET;
      fetch_pc_q    <= RESET_PC;
      hold_instr_q  <= 32'd0;
      hold_pc_q     <= 32'd0;
      redirect_pc_q <= 32'd0;
      instr_q       <= NOP_INSTR;
      pc_q          <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      redirect_pc_q <= redirect_pc_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed stimulus for if_stage with a scoreboard of expected instruction/pc pairs.
// Latency: expectations are pushed at each accept; the monitor pops on every cycle that loads a valid output.
// Backpressure: stall cycles hold outputs and are not counted as new outputs by the monitor.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall_pipeline;
  logic        is_jump;
  logic [31:0] jump_addr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        out_valid;

  int total;
  int bad;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];

  if_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_pipeline(stall_pipeline),
    .is_jump       (is_jump),
    .jump_addr     (jump_addr),
    .branch_taken  (branch_taken),
    .branch_addr   (branch_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .pc            (pc),
    .out_valid     (out_valid)
  );

  // Memory model: every word reads as its address plus 100.
  assign imem_rdata = imem_addr + 32'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_t e;
    e.instr = addr + 32'd100;
    e.pc    = addr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a valid output sampled after an edge where stall was low is a new instruction.
  always begin
    logic loaded;
    exp_t e;
    @(posedge clk);
    loaded = !stall_pipeline && !rst;
    #1;
    if (out_valid && loaded) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr=%h pc=%h with nothing expected", instruction, pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_instr", instruction, e.instr);
        check("sb_pc", pc, e.pc);
      end
    end
  end

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b1;
    stall_pipeline = 1'b0;
    is_jump        = 1'b0;
    jump_addr      = 32'd0;
    branch_taken   = 1'b0;
    branch_addr    = 32'd0;
    imem_ready     = 1'b1;

    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instruction, NOP);
    check("rst_pc", pc, 32'd0);
    check("rst_addr", imem_addr, RST_PC);

    // Release reset; first edge moves to fetch without a request.
    rst = 1'b0;
    step();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
    check("first_valid", {31'd0, out_valid}, 32'd0);

    // Streaming at one per cycle.
    for (int i = 0; i < 5; i++) begin
      check("stream_addr", imem_addr, i);
      push(i);
      step();
    end

    // Memory not ready at address 5 for three cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", imem_addr, 32'd5);
      check("wait_valid", {31'd0, out_valid}, 32'd0);
      check("wait_instr", instruction, NOP);
    end
    imem_ready = 1'b1;
    push(5);
    step();
    check("after_wait_addr", imem_addr, 32'd6);
    push(6);
    step();

    // Stall while address 7 is accepted: outputs hold pc 6 for two cycles.
    stall_pipeline = 1'b1;
    push(7);
    step();
    check("hold1_pc", pc, 32'd6);
    check("hold1_req", {31'd0, imem_req}, 32'd0);
    check("hold1_valid", {31'd0, out_valid}, 32'd1);
    step();
    check("hold2_pc", pc, 32'd6);
    check("hold2_req", {31'd0, imem_req}, 32'd0);
    stall_pipeline = 1'b0;
    step();
    check("unhold_req", {31'd0, imem_req}, 32'd1);
    check("unhold_addr", imem_addr, 32'd8);

    // Jump with request outstanding, then branch overrides it while draining.
    imem_ready = 1'b0;
    is_jump    = 1'b1;
    jump_addr  = 32'd40;
    step();
    check("drain1_addr", imem_addr, 32'd8);
    check("drain1_req", {31'd0, imem_req}, 32'd1);
    check("drain1_valid", {31'd0, out_valid}, 32'd0);
    is_jump      = 1'b0;
    branch_taken = 1'b1;
    branch_addr  = 32'd80;
    step();
    check("drain2_addr", imem_addr, 32'd8);
    check("drain2_valid", {31'd0, out_valid}, 32'd0);
    branch_taken = 1'b0;
    step();
    check("drain3_addr", imem_addr, 32'd8);
    check("drain3_instr", instruction, NOP);
    imem_ready = 1'b1;
    step();
    check("drained_addr", imem_addr, 32'd80);
    check("drained_valid", {31'd0, out_valid}, 32'd0);
    push(80);
    step();
    check("post_drain_addr", imem_addr, 32'd81);

    // Branch and jump together: branch target wins.
    branch_taken = 1'b1;
    branch_addr  = 32'd80;
    is_jump      = 1'b1;
    jump_addr    = 32'd40;
    step();
    check("both_addr", imem_addr, 32'd80);
    check("both_valid", {31'd0, out_valid}, 32'd0);
    check("both_pc", pc, 32'd0);
    check("both_instr", instruction, NOP);
    branch_taken = 1'b0;

    // Jump to the top of the address space; fetch wraps to zero.
    jump_addr = 32'hFFFF_FFFF;
    step();
    is_jump = 1'b0;
    check("wrap_pre_addr", imem_addr, 32'hFFFF_FFFF);
    push(32'hFFFF_FFFF);
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    push(32'd0);
    step();
    check("wrap_next_addr", imem_addr, 32'd1);

    // Redirect while a word is parked: parked word is dropped.
    stall_pipeline = 1'b1;
    step();
    check("hold3_req", {31'd0, imem_req}, 32'd0);
    is_jump   = 1'b1;
    jump_addr = 32'd20;
    step();
    check("hold_jump_addr", imem_addr, 32'd20);
    check("hold_jump_valid", {31'd0, out_valid}, 32'd0);
    check("hold_jump_req", {31'd0, imem_req}, 32'd1);
    is_jump        = 1'b0;
    stall_pipeline = 1'b0;
    push(20);
    step();

    // Reset with a request outstanding is abandoned immediately.
    imem_ready = 1'b0;
    step();
    check("pre_rst_addr", imem_addr, 32'd21);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_addr", imem_addr, RST_PC);
    step();
    rst        = 1'b0;
    imem_ready = 1'b1;
    step();
    check("rerst_addr", imem_addr, RST_PC);
    check("rerst_req", {31'd0, imem_req}, 32'd1);
    stall_pipeline = 1'b1;
    step();
    step();

    check("sb_leftover", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: IF_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: word address of the first fetch after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word driven to ID when no valid instruction is present.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_pipeline  in  1  hazard unit: ID is not advancing, so IF outputs hold.
- is_jump  in  1  ID: unconditional jump resolved this cycle.
- jump_addr  in  32  ID: jump target (word address).
- branch_taken  in  1  MEM: taken branch, flush required.
- branch_addr  in  32  MEM: branch target (word address).
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  instruction-memory word address.
- imem_ready  in  1  memory: imem_rdata valid; the request is accepted at this posedge.
- imem_rdata  in  32  memory read data.
- instruction  out  32  registered instruction to ID.
- pc  out  32  registered word address of the instruction (ID forms pc+1).
- out_valid  out  1  instruction/pc hold a real fetched instruction.

Function
REQ-005 Internal state: fetch_pc (32b), hold_instr/hold_pc buffer (32b each), redirect_pc (32b), and a four-state FSM: S_RESET, S_FETCH, S_HOLD, S_DRAIN.
REQ-006 Redirect priority, high to low: rst > branch_taken (branch_addr) > is_jump (jump_addr) > stall_pipeline > sequential.
REQ-007 imem_addr SHALL equal fetch_pc in S_RESET, S_FETCH and S_HOLD; in S_DRAIN it SHALL equal the address of the outstanding request.
REQ-008 imem_req SHALL be 1 only in S_FETCH and S_DRAIN; imem_addr SHALL be stable while imem_req=1 and imem_ready=0.
REQ-009 S_RESET: imem_req=0; next state is S_FETCH unconditionally.
REQ-010 S_FETCH with imem_ready=1 and no redirect and no stall: instruction<=imem_rdata, pc<=fetch_pc, out_valid<=1, fetch_pc<=fetch_pc+1; stay in S_FETCH. Throughput is one instruction per cycle; latency is one cycle from accept to output.
REQ-011 S_FETCH with imem_ready=1, stall=1 and no redirect: hold_instr/hold_pc<=imem_rdata/fetch_pc, fetch_pc<=fetch_pc+1, outputs unchanged; go to S_HOLD.
REQ-012 S_FETCH with imem_ready=0 and no redirect: if stall=1, outputs hold; otherwise instruction<=NOP_INSTR and out_valid<=0 (bubble).
REQ-013 Redirect in S_FETCH with imem_ready=1: discard imem_rdata, set fetch_pc<=target, stay in S_FETCH.
REQ-014 Redirect in S_FETCH with imem_ready=0: set redirect_pc<=target and go to S_DRAIN.
REQ-015 S_DRAIN: keep the old request until imem_ready=1, then discard the data, set fetch_pc<=redirect_pc and go to S_FETCH. A new redirect during S_DRAIN overwrites redirect_pc under REQ-006 priority, and completes the same way when it coincides with imem_ready=1.
REQ-016 S_HOLD: imem_req=0 and outputs hold while stall=1. On stall=0: instruction/pc<=hold_instr/hold_pc, out_valid<=1, go to S_FETCH.
REQ-017 Redirect in S_HOLD: drop the buffer, set fetch_pc<=target, go to S_FETCH.
REQ-018 Every redirect cycle (any state) SHALL set instruction<=NOP_INSTR, pc<=0 and out_valid<=0 at that posedge, regardless of stall. Outputs stay NOP in S_DRAIN.
REQ-019 fetch_pc increment is modulo 2^32: 32'hFFFF_FFFF+1 = 0 with no flag.
REQ-020 branch_taken and is_jump in the same cycle: the branch wins and the jump is ignored.

Reset
REQ-021 While rst=1, asynchronously: state=S_RESET, fetch_pc=RESET_PC, instruction=NOP_INSTR, pc=0, out_valid=0, imem_req=0, buffer and redirect_pc=0.
REQ-022 Reset mid-request (S_DRAIN or S_FETCH with imem_ready=0) SHALL abandon the request, with no handshake completion required. The first request after reset is to RESET_PC.

Verification
REQ-023 Reset release, imem_ready always 1, rdata=addr+100: imem_addr 0,1,2,…; instruction/pc = 100/0, 101/1, … one cycle after each accept; out_valid=1 from the 2nd posedge.
REQ-024 imem_ready low for 3 cycles at addr 5: imem_addr stays 5, outputs NOP/out_valid=0 for 3 cycles, then instruction for pc=5.
REQ-025 stall_pipeline high for 2 cycles while addr 7 is accepted: outputs hold pc=6 for 2 cycles, imem_req=0 in S_HOLD, then pc=7 with no duplicate or lost instruction.
REQ-026 is_jump=1, jump_addr=40 while a request is outstanding with imem_ready=0; branch_taken=1, branch_addr=80 one cycle later; ready after 3 cycles: old data discarded, next request at 80, out_valid=0 throughout.
REQ-027 branch_taken and is_jump in the same cycle with targets 80/40, and separately fetch_pc=32'hFFFF_FFFF: the next fetch is at 80; the wrap case fetches 32'h0000_0000 next.
